// File: rtl/i2s_master.sv
// ---------------------------------------------------------------------------
// i2s_master
//
// The FPGA drives the audio clocks (bclk, lrclk) for an ADAU1761-style codec.
// The module sends stereo DAC samples on sdata_o and receives stereo ADC
// samples from sdata_i. Each stereo word holds left in the upper BIT_DEPTH
// bits and right in the lower BIT_DEPTH bits.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   enabled           run/stop for clock generation and serial I/O
//   bclk, lrclk       bit clock and word clock (lrclk 0 = left), registered
//   sdata_o           serial DAC data, registered
//   sdata_i           serial ADC data (asynchronous, synchronized here)
//   dac_sample_*      AXI-stream slave: stereo word to transmit
//   adc_sample_*      AXI-stream master: stereo word received
//   underrun          one-cycle pulse: frame started with the DAC buffer empty
//   overrun           one-cycle pulse: an unaccepted ADC word was overwritten
// ---------------------------------------------------------------------------
module i2s_master #(
  parameter int BIT_DEPTH    = 24,
  parameter int CLK_PER_BCLK = 32,
  parameter int SLOTS        = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enabled,
  output logic                   bclk,
  output logic                   lrclk,
  output logic                   sdata_o,
  input  logic                   sdata_i,
  input  logic [2*BIT_DEPTH-1:0] dac_sample_data,
  input  logic                   dac_sample_valid,
  output logic                   dac_sample_ready,
  output logic [2*BIT_DEPTH-1:0] adc_sample_data,
  output logic                   adc_sample_valid,
  input  logic                   adc_sample_ready,
  output logic                   underrun,
  output logic                   overrun
);

  localparam int W     = 2 * BIT_DEPTH;
  localparam int DIV_W = $clog2(CLK_PER_BCLK);
  localparam int BIT_W = $clog2(2 * SLOTS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_BCLK - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_PER_BCLK / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOTS - 1);
  localparam logic [BIT_W-1:0] SLOTS_B  = BIT_W'(SLOTS);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [BIT_W-1:0] bit_cnt_next;
  logic [1:0]       sync_reg;
  logic [W-1:0]     tx_word_reg;
  logic [W-1:0]     rx_shift_reg;
  logic [W-1:0]     dac_buf_reg;
  logic             rx_primed_reg;

  logic             rise_tick;
  logic             fall_tick;
  logic             frame_start;

  // Per-slot lookup tables over the whole frame (index = bit_cnt):
  // tx_slot_bits is the bit to drive in that slot, rx_slot_mask marks the
  // slots whose bits are captured. Slot 0 of each half is the one-bclk I2S
  // delay after the lrclk edge, so data occupies slots 1..BIT_DEPTH.
  logic [2*SLOTS-1:0] tx_slot_bits;
  logic [2*SLOTS-1:0] rx_slot_mask;

  for (genvar gi = 0; gi < 2 * SLOTS; gi++) begin : g_slot
    localparam int S       = gi % SLOTS;
    localparam int CH_BASE = (gi >= SLOTS) ? 0 : BIT_DEPTH;
    if (S >= 1 && S <= BIT_DEPTH) begin : g_data
      assign tx_slot_bits[gi] = tx_word_reg[CH_BASE + BIT_DEPTH - S];
      assign rx_slot_mask[gi] = 1'b1;
    end else begin : g_pad
      assign tx_slot_bits[gi] = 1'b0;
      assign rx_slot_mask[gi] = 1'b0;
    end
  end

  assign rise_tick    = enabled && (div_cnt_reg == DIV_RISE);
  assign fall_tick    = enabled && (div_cnt_reg == DIV_LAST);
  assign bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
  assign frame_start  = fall_tick && (bit_cnt_next == '0);

  // Two-flop synchronizer for the asynchronous ADC data line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], sdata_i};
    end
  end

  // Clock generation and serial shifting. While stopped, the counters park
  // on the last count of the frame so the first enabled cycle is a fall tick
  // that starts a fresh left-channel frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg  <= DIV_LAST;
      bit_cnt_reg  <= BIT_LAST;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      sdata_o      <= 1'b0;
      rx_shift_reg <= '0;
    end else if (!enabled) begin
      div_cnt_reg  <= DIV_LAST;
      bit_cnt_reg  <= BIT_LAST;
      bclk         <= 1'b0;
      lrclk        <= 1'b0;
      sdata_o      <= 1'b0;
    end else begin
      div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 1'b1;
      if (rise_tick) begin
        bclk <= 1'b1;
        if (rx_slot_mask[bit_cnt_reg]) begin
          rx_shift_reg <= {rx_shift_reg[W-2:0], sync_reg[1]};
        end
      end
      if (fall_tick) begin
        bclk        <= 1'b0;
        bit_cnt_reg <= bit_cnt_next;
        lrclk       <= (bit_cnt_next >= SLOTS_B);
        sdata_o     <= tx_slot_bits[bit_cnt_next];
      end
    end
  end

  // DAC side: one-entry buffer; ready doubles as the "buffer empty" flag.
  // The frame-start load looks at the buffer as it was at the start of the
  // cycle, so a beat accepted on the boundary waits for the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_buf_reg      <= '0;
      dac_sample_ready <= 1'b1;
      tx_word_reg      <= '0;
      underrun         <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (frame_start) begin
        if (!dac_sample_ready) begin
          tx_word_reg <= dac_buf_reg;
        end else begin
          tx_word_reg <= '0;
          underrun    <= 1'b1;
        end
      end
      if (dac_sample_ready && dac_sample_valid) begin
        dac_buf_reg      <= dac_sample_data;
        dac_sample_ready <= 1'b0;
      end else if (frame_start && !dac_sample_ready) begin
        dac_sample_ready <= 1'b1;
      end
    end
  end

  // ADC side: publish the finished frame at each boundary, except for the
  // first boundary after reset/enable, whose preceding frame was never
  // captured. A publish in the same cycle as a handshake keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_sample_data  <= '0;
      adc_sample_valid <= 1'b0;
      rx_primed_reg    <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (!enabled) begin
        rx_primed_reg <= 1'b0;
      end else if (frame_start) begin
        rx_primed_reg <= 1'b1;
      end
      if (frame_start && rx_primed_reg) begin
        adc_sample_data  <= rx_shift_reg;
        adc_sample_valid <= 1'b1;
        overrun          <= adc_sample_valid && !adc_sample_ready;
      end else if (adc_sample_valid && adc_sample_ready) begin
        adc_sample_valid <= 1'b0;
      end
    end
  end

endmodule
